rob_completion_tracker: RTL
===========================

# rob_completion_tracker

Reorder-buffer completion tracker: the receiving end of the CDB's `FU_ROB_PACKET` broadcast. It allocates entries in program order at dispatch and marks entries executed from up to `N` CDB lanes per cycle, recording branch outcome and target. It retires up to `N` executed head entries per cycle in order and raises a squash when a retiring branch was mispredicted. It sits between dispatch and the CDB arbiter on one side and retire/fetch redirect on the other.

## Interface
- `SIZE`, default `` `ROB_SZ ``: entry count; power of two, ≥ `N`.
- `N`, default `` `N ``: dispatch, writeback and retire width.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dispatch_valid`  in  N  dispatch request per lane; must be a contiguous prefix from lane 0.
- `dispatch_packet`  in  `ROB_DISPATCH_PACKET`[N]  {dest_prn, PC, is_branch, pred_taken, pred_target}.
- `dispatch_robn`  out  `ROBN`[N]  entry index assigned to each lane: tail+i mod SIZE.
- `free_cnt`  out  $clog2(SIZE+1)  free entries at the start of this cycle.
- `fu_rob_packet`  in  `FU_ROB_PACKET`[N]  {robn, executed, branch_taken, target_addr} from the CDB.
- `retire_valid`  out  N  retiring lanes; always a contiguous prefix.
- `retire_packet`  out  `ROB_RETIRE_PACKET`[N]  {dest_prn, PC}.
- `squash`  out  1  a mispredicted branch retires this cycle.
- `squash_target`  out  `ADDR`  redirect PC; valid only while `squash` is high.

## Operation
- State per entry: valid, executed, dest_prn, PC, is_branch, pred_taken, pred_target, taken, target. Global state: head, tail, count.
- Dispatch:
  - Accepted lanes are k = popcount(dispatch_valid), clipped to `free_cnt`.
  - Lanes at or beyond `free_cnt` are dropped silently. The producer must not exceed `free_cnt`; the bench asserts this.
  - Accepted entries are written valid=1, executed=0.
  - tail advances by k.
- Writeback:
  - For each lane with `executed`=1 whose robn indexes a valid, not-yet-executed entry: set executed, taken←branch_taken, target←target_addr.
  - A packet to an invalid entry (stale after a squash) is ignored.
  - If two lanes carry the same robn, the lower lane wins.
- Retire:
  - Combinational prefix scan from head. Lane i retires iff entry head+i is valid and executed, every lower lane retires, and no lower lane is mispredicted.
  - Mispredict = is_branch & ((taken≠pred_taken) | (taken & target≠pred_target)).
  - A mispredicted branch itself retires (its lane is valid) and asserts `squash`.
  - `squash_target` = taken ? target : PC+4.
- Update on each clock edge:
  - Without squash: retired entries are invalidated and head advances by the retire count; count ← count + k − retired.
  - With squash: all entries are invalidated, head=tail=0, count=0, and dispatch and writeback in that cycle are discarded.
- Wrap-around: pointers are $clog2(SIZE) bits and wrap naturally. Full is count==SIZE; empty is count==0.
- Retirements do not free entries for dispatch in the same cycle; `free_cnt` reflects registered state only.

## Timing
- Reset (asynchronous assert on `reset_n` low; release synchronous to `clock`):
  - head=tail=count=0 and all valid/executed bits cleared.
  - `free_cnt`=SIZE, `retire_valid`=0, `squash`=0, `squash_target`=0, `dispatch_robn`[i]=i.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Dispatch at edge t makes the entry visible at t+1.
- The earliest writeback is in cycle t+1, setting executed at edge t+2. The entry can retire in cycle t+2.
- Minimum dispatch-to-retire latency: 2 cycles.
- `retire_*` and `squash` are combinational from registered state only. They have no combinational path from `fu_rob_packet` or `dispatch_*`.
- `free_cnt` and `dispatch_robn` are combinational from registers.

## Structure
- `ROB_DISPATCH_PACKET`, `ROB_RETIRE_PACKET` and `ROBN` go in `sys_defs.svh` alongside the existing `FU_ROB_PACKET`.
- One sub-module, `rob_retire_select`: the combinational N-lane prefix scan over the N head entries. It outputs retire_valid, retire count, squash and squash_target.
- Entry storage, pointers and the writeback match stay in the top level.

## Test plan
- Reset, then dispatch 2 ALU ops (N=2), then CDB-execute both in cycle 2 → retire_valid=2'b11 in cycle 3; free_cnt returns to SIZE.
- Dispatch A,B; execute B only → no retire. Then execute A → A and B retire in the same cycle, in order.
- Fill to SIZE entries → free_cnt=0 and extra dispatch lanes are dropped. Execute all → retire N per cycle; head and tail wrap past SIZE−1 to 0 correctly.
- Branch at PC 0x100 with pred_taken=0 and executed taken=1, target=0x200, followed by an executed younger op → branch retires alone, squash=1, squash_target=0x200. Next cycle count=0, and a stale writeback to the old robn is ignored.
- Branch predicted taken to 0x300, executed not-taken → squash_target=0x104. A correctly predicted branch retires with no squash.
- Drive reset_n low mid-stream with 5 entries live → outputs reach reset values before the next edge; free_cnt=SIZE.

Source files
------------

// File: rtl/rob_completion_tracker_pkg.sv
// Shared types for the reorder-buffer completion tracker: dispatch, CDB
// writeback and retire packets, plus the per-entry view used by retire select.
package rob_completion_tracker_pkg;

    localparam int ROB_SZ  = 8;
    localparam int N_LANES = 2;
    localparam int ROBN_W  = $clog2(ROB_SZ);

    typedef logic [31:0]       ADDR;
    typedef logic [5:0]        PRN;
    typedef logic [ROBN_W-1:0] ROBN;

    typedef struct packed {
        PRN   dest_prn;
        ADDR  pc;
        logic is_branch;
        logic pred_taken;
        ADDR  pred_target;
    } ROB_DISPATCH_PACKET;

    typedef struct packed {
        ROBN  robn;
        logic executed;
        logic branch_taken;
        ADDR  target_addr;
    } FU_ROB_PACKET;

    typedef struct packed {
        PRN  dest_prn;
        ADDR pc;
    } ROB_RETIRE_PACKET;

    // Snapshot of one ROB entry as seen by the retire scan.
    typedef struct packed {
        logic valid;
        logic executed;
        logic is_branch;
        logic pred_taken;
        logic taken;
        PRN   dest_prn;
        ADDR  pc;
        ADDR  pred_target;
        ADDR  target;
    } ROB_HEAD_ENTRY;

    // A branch is mispredicted when direction differs, or when it was taken
    // to a different target than predicted.
    function automatic logic is_mispredict(input ROB_HEAD_ENTRY e);
        return e.is_branch &&
               ((e.taken != e.pred_taken) || (e.taken && (e.target != e.pred_target)));
    endfunction

    // Correct fetch address after a mispredicted branch.
    function automatic ADDR redirect_pc(input ROB_HEAD_ENTRY e);
        return e.taken ? e.target : (e.pc + 32'd4);
    endfunction

endpackage

// File: rtl/rob_completion_tracker_retire_select.sv
// Combinational in-order retire scan over the N entries starting at head.
// A lane retires only if it and every lower lane are valid and executed and
// no lower lane is a mispredicted branch; the mispredicted branch itself retires.
module rob_retire_select
    import rob_completion_tracker_pkg::*;
#(
    parameter int N = N_LANES
) (
    input  ROB_HEAD_ENTRY [N-1:0]         head_entry,
    output logic [N-1:0]                  retire_valid,
    output logic [$clog2(N+1)-1:0]        retire_cnt,
    output logic                          squash,
    output ADDR                           squash_target
);

    localparam int RC_W = $clog2(N + 1);

    logic chain;

    // Prefix scan: stop at the first not-ready entry or right after a mispredict.
    always_comb begin
        retire_valid  = '0;
        retire_cnt    = '0;
        squash        = 1'b0;
        squash_target = '0;
        chain         = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (chain && head_entry[i].valid && head_entry[i].executed) begin
                retire_valid[i] = 1'b1;
                retire_cnt      = retire_cnt + RC_W'(1);
                if (is_mispredict(head_entry[i])) begin
                    squash        = 1'b1;
                    squash_target = redirect_pc(head_entry[i]);
                    chain         = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_completion_tracker.sv
// Reorder-buffer completion tracker: allocates entries in program order,
// marks them executed from the CDB, and retires executed head entries in order,
// flushing everything when a mispredicted branch retires.
module rob_completion_tracker
    import rob_completion_tracker_pkg::*;
#(
    parameter int SIZE = ROB_SZ,
    parameter int N    = N_LANES
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [N-1:0]                  dispatch_valid,
    input  ROB_DISPATCH_PACKET [N-1:0]    dispatch_packet,
    output ROBN [N-1:0]                   dispatch_robn,
    output logic [$clog2(SIZE+1)-1:0]     free_cnt,
    input  FU_ROB_PACKET [N-1:0]          fu_rob_packet,
    output logic [N-1:0]                  retire_valid,
    output ROB_RETIRE_PACKET [N-1:0]      retire_packet,
    output logic                          squash,
    output ADDR                           squash_target
);

    localparam int PTR_W = $clog2(SIZE);
    localparam int CNT_W = $clog2(SIZE + 1);
    localparam int RC_W  = $clog2(N + 1);

    // Control state
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [SIZE-1:0]  valid_q;
    logic [SIZE-1:0]  executed_q;

    // Entry payload
    ROB_DISPATCH_PACKET payload_q [SIZE];
    logic               taken_q   [SIZE];
    ADDR                target_q  [SIZE];

    logic [N-1:0]        dispatch_accept;
    logic [CNT_W-1:0]    accept_cnt;
    logic [SIZE-1:0]     wb_hit;
    logic [SIZE-1:0]     wb_taken;
    ADDR                 wb_target [SIZE];
    ROB_HEAD_ENTRY [N-1:0] head_entry;
    logic [RC_W-1:0]     retire_cnt;

    // Free space and per-lane allocation slots come straight from registers.
    always_comb begin
        free_cnt        = CNT_W'(SIZE) - count_q;
        dispatch_accept = '0;
        accept_cnt      = '0;
        for (int i = 0; i < N; i++) begin
            dispatch_robn[i] = ROBN'(tail_q + PTR_W'(i));
            if (dispatch_valid[i] && (CNT_W'(i) < free_cnt)) begin
                dispatch_accept[i] = 1'b1;
                accept_cnt         = accept_cnt + CNT_W'(1);
            end
        end
    end

    // CDB match; lanes scanned high to low so the lowest matching lane wins.
    always_comb begin
        wb_hit   = '0;
        wb_taken = '0;
        for (int e = 0; e < SIZE; e++) begin
            wb_target[e] = '0;
        end
        for (int l = N - 1; l >= 0; l--) begin
            if (fu_rob_packet[l].executed &&
                valid_q[fu_rob_packet[l].robn] &&
                !executed_q[fu_rob_packet[l].robn]) begin
                wb_hit[fu_rob_packet[l].robn]    = 1'b1;
                wb_taken[fu_rob_packet[l].robn]  = fu_rob_packet[l].branch_taken;
                wb_target[fu_rob_packet[l].robn] = fu_rob_packet[l].target_addr;
            end
        end
    end

    // Gather the N entries starting at head for the retire scan.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            head_entry[i].valid       = valid_q[head_q + PTR_W'(i)];
            head_entry[i].executed    = executed_q[head_q + PTR_W'(i)];
            head_entry[i].is_branch   = payload_q[head_q + PTR_W'(i)].is_branch;
            head_entry[i].pred_taken  = payload_q[head_q + PTR_W'(i)].pred_taken;
            head_entry[i].taken       = taken_q[head_q + PTR_W'(i)];
            head_entry[i].dest_prn    = payload_q[head_q + PTR_W'(i)].dest_prn;
            head_entry[i].pc          = payload_q[head_q + PTR_W'(i)].pc;
            head_entry[i].pred_target = payload_q[head_q + PTR_W'(i)].pred_target;
            head_entry[i].target      = target_q[head_q + PTR_W'(i)];
            retire_packet[i].dest_prn = head_entry[i].dest_prn;
            retire_packet[i].pc       = head_entry[i].pc;
        end
    end

    rob_retire_select #(
        .N (N)
    ) u_retire_select (
        .head_entry    (head_entry),
        .retire_valid  (retire_valid),
        .retire_cnt    (retire_cnt),
        .squash        (squash),
        .squash_target (squash_target)
    );

    // Pointer, occupancy and valid/executed update; squash flushes the whole buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            executed_q <= '0;
        end else if (squash) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            executed_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (retire_valid[i]) begin
                    valid_q[head_q + PTR_W'(i)] <= 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (dispatch_accept[i]) begin
                    valid_q[tail_q + PTR_W'(i)]    <= 1'b1;
                    executed_q[tail_q + PTR_W'(i)] <= 1'b0;
                end
            end
            for (int e = 0; e < SIZE; e++) begin
                if (wb_hit[e]) begin
                    executed_q[e] <= 1'b1;
                end
            end
            head_q  <= head_q + PTR_W'(retire_cnt);
            tail_q  <= tail_q + PTR_W'(accept_cnt);
            count_q <= count_q + accept_cnt - CNT_W'(retire_cnt);
        end
    end

    // Payload capture; entries written here are only observed once marked valid/executed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (dispatch_accept[i]) begin
                payload_q[tail_q + PTR_W'(i)] <= dispatch_packet[i];
            end
        end
        for (int e = 0; e < SIZE; e++) begin
            if (wb_hit[e]) begin
                taken_q[e]  <= wb_taken[e];
                target_q[e] <= wb_target[e];
            end
        end
    end

endmodule
